// File: rtl/xcorr_search_ctrl.sv
// Pitch-shift cross-correlation search sequencer.
// Optional macro XCORR_COARSE_STRIDE_EN selects a candidate step of 2.
module xcorr_search_ctrl #(
  parameter int NUM_CAND   = 2048,
  parameter int WINDOW_LEN = 4,
  parameter int ADDR_W     = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_search_base,
  input  logic [ADDR_W-1:0] i_pred_base,
  output logic [ADDR_W-1:0] o_poss_addr,
  output logic [ADDR_W-1:0] o_pred_addr,
  output logic              o_rd_en,
  output logic              o_corr_clr,
  output logic [10:0]       o_counter,
  output logic [9:0]        o_data_counter,
  input  logic [10:0]       i_index,
  output logic [10:0]       o_index,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [10:0] C_LAST = 11'(NUM_CAND - 1);
  localparam logic [9:0]  S_LAST = 10'(WINDOW_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [10:0]       c, c_nxt;
  logic [9:0]        s, s_nxt;
  logic [10:0]       c_step;
  logic [ADDR_W-1:0] search_base;
  logic [ADDR_W-1:0] pred_base;
  logic              latch_bases;
  logic              run;

`ifdef XCORR_COARSE_STRIDE_EN
  assign c_step = {c[9:0], 1'b0};
`else
  assign c_step = c;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      c     <= '0;
      s     <= '0;
    end else begin
      state <= state_nxt;
      c     <= c_nxt;
      s     <= s_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      search_base <= '0;
      pred_base   <= '0;
    end else if (latch_bases) begin
      search_base <= i_search_base;
      pred_base   <= i_pred_base;
    end
  end

  always_comb begin
    state_nxt   = state;
    c_nxt       = c;
    s_nxt       = s;
    latch_bases = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          latch_bases = 1'b1;
          state_nxt   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        c_nxt     = '0;
        s_nxt     = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (s == S_LAST) begin
          s_nxt = '0;
          if (c == C_LAST) begin
            state_nxt = S_DRAIN;
          end else begin
            c_nxt = c + 11'd1;
          end
        end else begin
          s_nxt = s + 10'd1;
        end
      end
      S_DRAIN:  state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign run        = (state == S_RUN);
  assign o_rd_en    = run;
  assign o_corr_clr = (state == S_CLEAR);
  assign o_busy     = (state != S_IDLE);

  // Addresses wrap silently modulo 2^ADDR_W.
  assign o_pred_addr = run ? pred_base + ADDR_W'(s) : '0;
  assign o_poss_addr = run
    ? search_base + ADDR_W'(c_step) + ADDR_W'(s)
    : '0;

  // Counters trail the issue by one cycle to line up with buffer data;
  // the sample index is forced to 0 whenever no data is in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_counter      <= '0;
      o_data_counter <= '0;
    end else if (run) begin
      o_counter      <= c_step;
      o_data_counter <= s;
    end else begin
      o_data_counter <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_index <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= (state == S_FINISH);
      if (state == S_FINISH) begin
        o_index <= i_index;
      end
    end
  end

endmodule

// File: tb/tb_xcorr_search_ctrl.sv
// Directed bench for xcorr_search_ctrl with a behavioural
// sample buffer and correlator.
module tb_xcorr_search_ctrl;

  localparam int NC = 4;
  localparam int WL = 4;
  localparam int AW = 20;
`ifdef XCORR_COARSE_STRIDE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_search_base = '0;
  logic [AW-1:0] i_pred_base = '0;
  logic [AW-1:0] o_poss_addr;
  logic [AW-1:0] o_pred_addr;
  logic          o_rd_en;
  logic          o_corr_clr;
  logic [10:0]   o_counter;
  logic [9:0]    o_data_counter;
  logic [10:0]   i_index;
  logic [10:0]   o_index;
  logic          o_busy;
  logic          o_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xcorr_search_ctrl #(
    .NUM_CAND(NC),
    .WINDOW_LEN(WL),
    .ADDR_W(AW)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_search_base(i_search_base),
    .i_pred_base(i_pred_base),
    .o_poss_addr(o_poss_addr),
    .o_pred_addr(o_pred_addr),
    .o_rd_en(o_rd_en),
    .o_corr_clr(o_corr_clr),
    .o_counter(o_counter),
    .o_data_counter(o_data_counter),
    .i_index(i_index),
    .o_index(o_index),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  // Predict frame 1,2,3,4 at 0..3; candidate data 1,2,3,4 at 0x102..0x105,
  // so the correlation peaks at candidate offset 2.
  function automatic int bufval(input logic [AW-1:0] a);
    if (a < 20'd4) return int'(a) + 1;
    if (a >= 20'h102 && a <= 20'h105) return int'(a) - 32'h101;
    return 0;
  endfunction

  int          pd, qd, acc, mx;
  logic        rdv;
  logic [10:0] best;
  assign i_index = best;

  always @(posedge clk) begin
    if (i_rst || o_corr_clr) begin
      rdv <= 1'b0; acc <= 0; mx <= 0; best <= '0;
      pd <= 0; qd <= 0;
    end else begin
      rdv <= o_rd_en;
      pd  <= bufval(o_pred_addr);
      qd  <= bufval(o_poss_addr);
      if (rdv) begin
        if (int'(o_data_counter) == WL - 1) begin
          acc <= 0;
          if (acc + pd * qd > mx) begin
            mx <= acc + pd * qd; best <= o_counter;
          end
        end else begin
          acc <= acc + pd * qd;
        end
      end
    end
  end

  task automatic run_search(
    input logic [AW-1:0] sb,
    input logic [AW-1:0] pb,
    input int            pulse_cyc,
    input int            rst_cyc,
    input logic [10:0]   prev_idx,
    input logic          chk_idx
  );
    int k, c, s, kd;
    logic rn, dv;
    logic [AW-1:0] ea;
    i_search_base = sb;
    i_pred_base   = pb;
    i_start       = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      i_start = (cyc == pulse_cyc);
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        i_rst = 1'b0;
        checks++;
        if ({o_rd_en, o_corr_clr, o_busy, o_done} !== 4'b0 ||
            o_index !== 11'd0 || o_counter !== 11'd0 ||
            o_data_counter !== 10'd0 || o_poss_addr !== '0 ||
            o_pred_addr !== '0) begin
          errors++;
          $display("FAIL abort: busy=%0b done=%0b idx=%0d cnt=%0d want all 0",
                   o_busy, o_done, o_index, o_counter);
        end
        return;
      end
      rn = (cyc >= 2 && cyc <= 17);
      dv = (cyc >= 3 && cyc <= 18);
      k  = cyc - 2; c = k / WL; s = k % WL;
      kd = cyc - 3;
      ea = rn ? sb + AW'(c * STEP + s) : '0;
      checks++;
      if (o_corr_clr !== (cyc == 1)) begin
        errors++;
        $display("FAIL corr_clr c%0d: got %0b", cyc, o_corr_clr);
      end
      checks++;
      if (o_rd_en !== rn) begin
        errors++;
        $display("FAIL rd_en c%0d: got %0b want %0b", cyc, o_rd_en, rn);
      end
      checks++;
      if (o_busy !== (cyc <= 19)) begin
        errors++;
        $display("FAIL busy c%0d: got %0b", cyc, o_busy);
      end
      checks++;
      if (o_done !== (cyc == 20)) begin
        errors++;
        $display("FAIL done c%0d: got %0b", cyc, o_done);
      end
      checks++;
      if (o_poss_addr !== ea) begin
        errors++;
        $display("FAIL poss_addr c%0d: got %h want %h", cyc, o_poss_addr, ea);
      end
      checks++;
      if (o_pred_addr !== (rn ? pb + AW'(s) : '0)) begin
        errors++;
        $display("FAIL pred_addr c%0d: got %h", cyc, o_pred_addr);
      end
      checks++;
      if (o_data_counter !== (dv ? 10'(kd % WL) : 10'd0)) begin
        errors++;
        $display("FAIL data_counter c%0d: got %0d", cyc, o_data_counter);
      end
      if (dv || cyc >= 19) begin
        checks++;
        if (o_counter !== (dv ? 11'((kd / WL) * STEP) : 11'((NC - 1) * STEP))) begin
          errors++;
          $display("FAIL counter c%0d: got %0d", cyc, o_counter);
        end
      end
      if (cyc < 20) begin
        checks++;
        if (o_index !== prev_idx) begin
          errors++;
          $display("FAIL index_hold c%0d: got %0d want %0d",
                   cyc, o_index, prev_idx);
        end
      end else if (chk_idx) begin
        checks++;
        if (o_index !== 11'd2) begin
          errors++;
          $display("FAIL index c%0d: got %0d want 2", cyc, o_index);
        end
      end
      if (cyc == rst_cyc) i_rst = 1'b1;
    end
  endtask

  task automatic test_reset;
    int seen;
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_rd_en, o_corr_clr, o_busy, o_done} !== 4'b0 ||
        o_index !== 11'd0 || o_counter !== 11'd0 ||
        o_data_counter !== 10'd0 || o_poss_addr !== '0 ||
        o_pred_addr !== '0) begin
      errors++;
      $display("FAIL reset: outputs not all 0 (busy=%0b rd=%0b)",
               o_busy, o_rd_en);
    end
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_rd_en || o_busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL idle: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_search;
    run_search(20'h100, 20'h0, -1, -1, 11'd0, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_search(20'h100, 20'h0, -1, -1, 11'd2, 1'b1);
  endtask

  task automatic test_ignore_start;
    run_search(20'h100, 20'h0, 5, -1, 11'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%0b busy=%0b want 0 0",
               o_done, o_busy);
    end
  endtask

  task automatic test_abort;
    run_search(20'h100, 20'h0, -1, 10, 11'd2, 1'b0);
    run_search(20'h100, 20'h0, -1, -1, 11'd0, 1'b1);
  endtask

  task automatic test_wrap;
    run_search(20'hFFFFE, 20'h0, -1, -1, 11'd2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_search();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_wrap();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xcorr_search_ctrl.md
Name: xcorr_search_ctrl

Overview:
- Sequences one pitch-shift correlation search over the serial cross-correlation datapath.
- On start it clears the correlator and reads a predict frame plus NUM_CAND candidate windows from a dual-read sample buffer.
- It drives the correlator's candidate and sample counters aligned with the returned data, then latches the winning index and pulses done.
- Sits between the pitch top-level FSM and the correlator/buffer.

Parameters:
- NUM_CAND, 2048, number of candidate offsets searched (1..2048; fits the 11-bit candidate counter).
- WINDOW_LEN, 4, samples per correlation window. Must be ≥2, ≤1024, and equal to the correlator's compare point plus one.
- ADDR_W, 20, buffer address width.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_search_base  in  ADDR_W  base address of the candidate region
- i_pred_base  in  ADDR_W  base address of the predict frame
- o_poss_addr  out  ADDR_W  candidate sample read address
- o_pred_addr  out  ADDR_W  predict sample read address
- o_rd_en  out  1  read strobe; buffer data is valid exactly one cycle later
- o_corr_clr  out  1  one-cycle clear to the correlator reset input
- o_counter  out  11  candidate index to the correlator, aligned with data
- o_data_counter  out  10  sample index to the correlator, aligned with data
- i_index  in  11  correlator's current best index
- o_index  out  11  latched result
- o_busy  out  1  high from CLEAR through FINISH
- o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, state IDLE. i_rst mid-search aborts immediately: no done, o_index becomes 0.
- States: IDLE → CLEAR → RUN → DRAIN → FINISH → IDLE.
- IDLE:
  - On i_start, latch i_search_base and i_pred_base, then go to CLEAR.
  - i_start in any other state is ignored.
- CLEAR:
  - o_corr_clr=1 for exactly one cycle; go to RUN with c=0, s=0.
- RUN, one issue per cycle:
  - o_rd_en=1.
  - o_pred_addr = pred_base + s.
  - o_poss_addr = search_base + c*STEP + s, where STEP=1 (see Optional Feature).
  - Address arithmetic is mod 2^ADDR_W, wrapping silently.
  - s increments each cycle. At s=WINDOW_LEN-1, s returns to 0 and c increments.
  - After issuing (NUM_CAND-1, WINDOW_LEN-1), go to DRAIN.
  - RUN lasts NUM_CAND*WINDOW_LEN cycles.
- Data alignment:
  - o_counter and o_data_counter are registered copies of the (c,s) issued the previous cycle, so they coincide with buffer data.
  - In every cycle with no data valid, o_data_counter=0 and o_counter holds its value. This prevents a spurious compare in the correlator.
  - When STEP=2, o_counter carries c*STEP.
- DRAIN: one cycle; the last sample is presented to the correlator.
- FINISH: one cycle, so the correlator's max register settles.
  - At the end of FINISH, o_index <= i_index and o_done <= 1 for the next cycle only.
  - Go to IDLE.
- Latency: for i_start sampled at edge 0, o_done is high in cycle NUM_CAND*WINDOW_LEN+4, with o_index valid in the same cycle.
- o_index holds until the next FINISH or reset.
- A start accepted in the same cycle o_done is high is legal; o_index holds the prior result until the new FINISH.
- If all correlation sums are ≤0, the result is index 0, because the correlator clears its max to 0.

Optional Feature:
- Macro: XCORR_COARSE_STRIDE_EN.
- Defined:
  - Candidate step STEP=2.
  - Search covers offsets 0,2,…,2*(NUM_CAND-1).
  - o_counter = 2c, and therefore requires 2*(NUM_CAND-1) ≤ 2047.
- Undefined: STEP=1. No extra logic is compiled.

Test Plan:
- Reset then idle, with NUM_CAND=4 and WINDOW_LEN=4 → all outputs 0; i_start=0 for 50 cycles → no o_rd_en.
- Start with search_base=0x100 and pred_base=0x000:
  - o_corr_clr in cycle 1.
  - o_poss_addr runs 0x100..0x103, 0x101..0x104, …, 0x103..0x106 over cycles 2–17.
  - o_pred_addr cycles 0..3.
  - o_done in cycle 20.
- Buffer model with peak correlation at candidate 2 → o_index=2 with o_done. o_data_counter is never 3 outside data cycles.
- i_start pulsed at cycle 5 mid-search → ignored; single o_done in cycle 20.
- i_rst asserted in cycle 10 → next cycle all outputs 0 and state IDLE. A fresh start then completes normally.
- Search_base=0xFFFFE with XCORR_COARSE_STRIDE_EN → addresses wrap to 0x00000…; o_counter=0,2,4,6.
